// File: rtl/samples_pkg.sv
`default_nettype none
// samples_pkg - sample type and capture-source state encoding shared by the sparse sample path.
// Revision: 1.0
package samples_pkg;

    typedef logic [9:0] smpl_t;

    typedef enum logic [2:0] {
        S_FILL   = 3'd0,
        S_ARMED  = 3'd1,
        S_POST   = 3'd2,
        S_AVAIL  = 3'd3,
        S_STREAM = 3'd4
    } src_state_t;

endpackage
`default_nettype wire

// File: rtl/smpl_ram.sv
`default_nettype none
// smpl_ram - simple dual-port sample RAM, one write port and a registered, resettable read port.
// Revision: 1.0
module smpl_ram
    import samples_pkg::*;
#(
    parameter int SIZE = 256,
    parameter int AW   = $clog2(SIZE)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  smpl_t         i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output smpl_t         o_rdata
);

    smpl_t r_mem [SIZE];
    smpl_t r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read register holds its value whenever no read is requested.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/samples_sparse_src.sv
`default_nettype none
// samples_sparse_src - decimating triggered capture into a circular buffer; serves a frozen frame on request.
// Revision: 1.0
module samples_sparse_src
    import samples_pkg::*;
#(
    parameter int SIZE    = 256,
    parameter int PRE     = 128,
    parameter int DIV     = 4,
    parameter int TIMEOUT = 65535
) (
    input  logic       clkSmpl,
    input  logic       reset,
    input  logic [9:0] adc,
    input  logic [9:0] trig_level,
    input  logic       trig_rising,
    input  logic       auto_en,
    input  logic       smpl_req,
    output logic       smpl_avail,
    output logic [9:0] smpl,
    output logic       triggered
);

    localparam int AW = $clog2(SIZE);
    localparam int CW = AW + 1;
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [DW-1:0] c_DIV_LAST  = DW'(DIV - 1);
    localparam logic [AW-1:0] c_PRE       = AW'(PRE);
    localparam logic [AW-1:0] c_FILL_LAST = AW'(PRE - 1);
    localparam logic [AW-1:0] c_POST_LAST = AW'(SIZE - PRE - 1);
    localparam logic [CW-1:0] c_SIZE      = CW'(SIZE);
    localparam logic [CW-1:0] c_CNT_LAST  = CW'(SIZE - 1);
    localparam logic [TW-1:0] c_TO_LAST   = TW'(TIMEOUT - 1);
    localparam bit            c_POST_ONE  = (SIZE - PRE == 1);

    src_state_t    r_state;
    src_state_t    w_next;
    logic [DW-1:0] r_dcnt;
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [AW-1:0] r_tp;
    logic [AW-1:0] r_fcnt;
    logic [AW-1:0] r_pcnt;
    logic [CW-1:0] r_cnt;
    logic [TW-1:0] r_tcnt;
    smpl_t         r_prev;
    logic          r_trig;

    logic          w_st;
    logic          w_streaming;
    logic          w_store;
    logic          w_trig;
    logic          w_capture;
    logic          w_freeze;
    logic          w_rd;
    logic [AW-1:0] w_tp;

    always_comb begin
        w_st        = (r_dcnt == '0);
        w_streaming = (r_state == S_AVAIL) || (r_state == S_STREAM);
        w_store     = w_st && !w_streaming;
        w_trig      = trig_rising ? ((r_prev < trig_level) && (adc >= trig_level))
                                  : ((r_prev > trig_level) && (adc <= trig_level));
        // The timeout fires on the strobe that brings the Armed store count up to TIMEOUT.
        w_capture   = w_st && (r_state == S_ARMED)
                      && (w_trig || (auto_en && (r_tcnt == c_TO_LAST)));
        w_freeze    = (w_capture && c_POST_ONE)
                      || (w_st && (r_state == S_POST) && (r_pcnt == c_POST_LAST));
        w_rd        = w_streaming && smpl_req && (r_cnt < c_SIZE);
        w_tp        = (r_state == S_POST) ? r_tp : r_wp;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FILL:   if (w_store && (r_fcnt == c_FILL_LAST)) w_next = S_ARMED;
            S_ARMED:  if (w_freeze) w_next = S_AVAIL;
                      else if (w_capture) w_next = S_POST;
            S_POST:   if (w_freeze) w_next = S_AVAIL;
            S_AVAIL:  if (w_rd) w_next = (r_cnt == c_CNT_LAST) ? S_FILL : S_STREAM;
            S_STREAM: if (w_rd && (r_cnt == c_CNT_LAST)) w_next = S_FILL;
            default:  w_next = S_FILL;
        endcase
    end

    always_ff @(posedge clkSmpl) begin
        if (reset) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clkSmpl) begin
        if (reset) begin
            r_dcnt <= '0;
            r_wp   <= '0;
            r_rp   <= '0;
            r_tp   <= '0;
            r_fcnt <= '0;
            r_pcnt <= '0;
            r_cnt  <= '0;
            r_tcnt <= '0;
            r_prev <= '0;
            r_trig <= 1'b0;
        end else begin
            r_trig <= w_freeze;
            // Holding the decimator at zero while serving restarts it cleanly on Fill entry.
            if (w_streaming || (r_dcnt == c_DIV_LAST)) begin
                r_dcnt <= '0;
            end else begin
                r_dcnt <= r_dcnt + 1'b1;
            end
            if (w_store) begin
                r_wp   <= r_wp + 1'b1;
                r_prev <= adc;
            end
            if (r_state != S_FILL) begin
                r_fcnt <= '0;
            end else if (w_store) begin
                r_fcnt <= r_fcnt + 1'b1;
            end
            if (r_state != S_ARMED) begin
                r_tcnt <= '0;
            end else if (w_st && (r_tcnt != c_TO_LAST)) begin
                r_tcnt <= r_tcnt + 1'b1;
            end
            if (w_capture) begin
                r_tp   <= r_wp;
                r_pcnt <= AW'(1);
            end else if ((r_state == S_POST) && w_store) begin
                r_pcnt <= r_pcnt + 1'b1;
            end
            if (w_freeze) begin
                r_rp  <= w_tp - c_PRE;
                r_cnt <= '0;
            end else if (w_rd) begin
                r_rp  <= r_rp + 1'b1;
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    smpl_ram #(
        .SIZE (SIZE),
        .AW   (AW)
    ) u_ram (
        .clk     (clkSmpl),
        .rst     (reset),
        .i_we    (w_store),
        .i_waddr (r_wp),
        .i_wdata (adc),
        .i_re    (w_rd),
        .i_raddr (r_rp),
        .o_rdata (smpl)
    );

    assign smpl_avail = w_streaming;
    assign triggered  = r_trig;

endmodule
`default_nettype wire

// File: tb/tb_samples_sparse_src.sv
`default_nettype none
// tb_samples_sparse_src - scoreboard bench for the capture-side sample source (DIV=1 and DIV=4 instances).
// Revision: 1.0
module tb_samples_sparse_src;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [9:0] adc;
    logic [9:0] trig_level;
    logic       trig_rising;
    logic       auto_en;
    logic       smpl_req;
    logic       av1, tg1, av4, tg4;
    logic [9:0] s1, s4;

    samples_sparse_src #(.SIZE(16), .PRE(4), .DIV(1), .TIMEOUT(20)) u1 (
        .clkSmpl(clk), .reset(rst), .adc(adc), .trig_level(trig_level),
        .trig_rising(trig_rising), .auto_en(auto_en), .smpl_req(smpl_req),
        .smpl_avail(av1), .smpl(s1), .triggered(tg1)
    );

    samples_sparse_src #(.SIZE(16), .PRE(4), .DIV(4), .TIMEOUT(65535)) u4 (
        .clkSmpl(clk), .reset(rst), .adc(adc), .trig_level(trig_level),
        .trig_rising(trig_rising), .auto_en(auto_en), .smpl_req(smpl_req),
        .smpl_avail(av4), .smpl(s4), .triggered(tg4)
    );

    int         checks   = 0;
    int         failures = 0;
    logic [9:0] q[$];
    int         adc_mode;   // 0 hold, 1 ramp up, 2 ramp down
    int         req_mode;   // 0 low, 1 high, 2 toggle
    logic       acc, av, tg;
    logic [9:0] s;
    logic [9:0] e;

    // One clock: records whether this edge accepted a request, samples outputs, drives next inputs.
    task automatic step(input bit use4);
        logic pre;
        pre = smpl_req && (use4 ? av4 : av1);
        @(posedge clk);
        #1;
        acc = pre;
        s   = use4 ? s4 : s1;
        av  = use4 ? av4 : av1;
        tg  = use4 ? tg4 : tg1;
        if (adc_mode == 1) adc = adc + 10'd1;
        else if (adc_mode == 2) adc = adc - 10'd1;
        if (req_mode == 2) smpl_req = ~smpl_req;
    endtask

    task automatic apply_reset(input logic [9:0] start, input int amode, input int rmode);
        rst      = 1'b1;
        adc      = start;
        adc_mode = amode;
        req_mode = rmode;
        smpl_req = (rmode != 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        trig_level = 10'd100; trig_rising = 1'b1; auto_en = 1'b0;
        rst = 1'b1; adc = 10'd0; smpl_req = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (av1 !== 1'b0) begin failures++; $display("FAIL reset_avail got=%b exp=0", av1); end
        checks++; if (s1 !== 10'd0) begin failures++; $display("FAIL reset_smpl got=%0d exp=0", s1); end
        checks++; if (tg1 !== 1'b0) begin failures++; $display("FAIL reset_triggered got=%b exp=0", tg1); end
        checks++; if (av4 !== 1'b0) begin failures++; $display("FAIL reset_avail_div4 got=%b exp=0", av4); end
    endtask

    task automatic test_ramp(input int rmode);
        int got, ntrig, tstep;
        trig_level = 10'd100; trig_rising = 1'b1; auto_en = 1'b0;
        apply_reset(10'd0, 1, rmode);
        q.delete();
        for (int i = 0; i < 16; i++) q.push_back(10'(96 + i));
        got = 0; ntrig = 0; tstep = 0;
        for (int c = 1; c <= 1000 && got < 16; c++) begin
            step(1'b0);
            if (tg) begin
                ntrig++;
                if (tstep == 0) tstep = c;
                checks++; if (av !== 1'b1) begin failures++; $display("FAIL ramp_avail_at_freeze got=%b exp=1", av); end
            end
            if (acc) begin
                e = q.pop_front();
                checks++; if (s !== e) begin failures++; $display("FAIL ramp_sample[%0d] mode=%0d got=%0d exp=%0d", got, rmode, s, e); end
                got++;
            end
        end
        checks++; if (got != 16) begin failures++; $display("FAIL ramp_drain_timeout got=%0d exp=16", got); end
        checks++; if (av !== 1'b0) begin failures++; $display("FAIL ramp_avail_after_drain got=%b exp=0", av); end
        checks++; if (ntrig != 1) begin failures++; $display("FAIL ramp_trig_count got=%0d exp=1", ntrig); end
        // Trigger sample stored on edge 101, eleven more Post stores, freeze visible after edge 112.
        checks++; if (tstep != 112) begin failures++; $display("FAIL ramp_trig_cycle got=%0d exp=112", tstep); end
    endtask

    task automatic test_timeout();
        int got, tstep;
        trig_level = 10'd100; trig_rising = 1'b1; auto_en = 1'b1;
        apply_reset(10'd0, 0, 1);
        q.delete();
        for (int i = 0; i < 16; i++) q.push_back(10'd0);
        got = 0; tstep = 0;
        for (int c = 1; c <= 1000 && got < 16; c++) begin
            step(1'b0);
            if (tg && tstep == 0) tstep = c;
            if (acc) begin
                e = q.pop_front();
                checks++; if (s !== e) begin failures++; $display("FAIL timeout_sample[%0d] got=%0d exp=%0d", got, s, e); end
                got++;
            end
        end
        checks++; if (got != 16) begin failures++; $display("FAIL timeout_drain got=%0d exp=16", got); end
        // Armed on edge 4, capture 20 strobes later (edge 24), freeze after edge 35.
        checks++; if (tstep != 35) begin failures++; $display("FAIL timeout_trig_cycle got=%0d exp=35", tstep); end
        auto_en = 1'b0;
    endtask

    task automatic test_div4();
        int got, tstep;
        trig_level = 10'd98; trig_rising = 1'b1; auto_en = 1'b0;
        apply_reset(10'd0, 1, 1);
        q.delete();
        for (int i = 0; i < 16; i++) q.push_back(10'(84 + 4 * i));
        got = 0; tstep = 0;
        for (int c = 1; c <= 2000 && got < 16; c++) begin
            step(1'b1);
            if (tg && tstep == 0) tstep = c;
            if (acc) begin
                e = q.pop_front();
                checks++; if (s !== e) begin failures++; $display("FAIL div4_sample[%0d] got=%0d exp=%0d", got, s, e); end
                got++;
            end
        end
        checks++; if (got != 16) begin failures++; $display("FAIL div4_drain got=%0d exp=16", got); end
        checks++; if (tstep != 145) begin failures++; $display("FAIL div4_trig_cycle got=%0d exp=145", tstep); end
    endtask

    task automatic test_reset_mid();
        int got;
        trig_level = 10'd100; trig_rising = 1'b1; auto_en = 1'b0;
        apply_reset(10'd0, 1, 1);
        got = 0;
        for (int c = 1; c <= 1000 && got < 5; c++) begin
            step(1'b0);
            if (acc) got++;
        end
        checks++; if (got != 5) begin failures++; $display("FAIL midreset_partial got=%0d exp=5", got); end
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (av1 !== 1'b0) begin failures++; $display("FAIL midreset_avail got=%b exp=0", av1); end
        checks++; if (s1 !== 10'd0) begin failures++; $display("FAIL midreset_smpl got=%0d exp=0", s1); end
        rst = 1'b0;
        adc = 10'd0;
        q.delete();
        for (int i = 0; i < 16; i++) q.push_back(10'(96 + i));
        got = 0;
        for (int c = 1; c <= 1000 && got < 16; c++) begin
            step(1'b0);
            if (acc) begin
                e = q.pop_front();
                checks++; if (s !== e) begin failures++; $display("FAIL midreset_sample[%0d] got=%0d exp=%0d", got, s, e); end
                got++;
            end
        end
        checks++; if (got != 16) begin failures++; $display("FAIL midreset_drain got=%0d exp=16", got); end
    endtask

    task automatic test_falling();
        int got;
        trig_level = 10'd500; trig_rising = 1'b0; auto_en = 1'b0;
        apply_reset(10'd1023, 2, 1);
        q.delete();
        for (int i = 0; i < 16; i++) q.push_back(10'(504 - i));
        got = 0;
        for (int c = 1; c <= 2000 && got < 16; c++) begin
            step(1'b0);
            if (acc) begin
                e = q.pop_front();
                checks++; if (s !== e) begin failures++; $display("FAIL fall_sample[%0d] got=%0d exp=%0d", got, s, e); end
                got++;
            end else if (got == 0) begin
                checks++; if (s !== 10'd0) begin failures++; $display("FAIL fall_smpl_held c=%0d got=%0d exp=0", c, s); end
            end
        end
        checks++; if (got != 16) begin failures++; $display("FAIL fall_drain got=%0d exp=16", got); end
    endtask

    initial begin
        rst = 1'b1; adc = '0; trig_level = '0; trig_rising = 1'b1; auto_en = 1'b0; smpl_req = 1'b0;
        adc_mode = 0; req_mode = 0;
        test_reset();
        test_ramp(1);
        test_ramp(2);
        test_timeout();
        test_div4();
        test_reset_mid();
        test_falling();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
